// File: rtl/dct8_pkg.sv
// rtl/dct8_pkg.sv - shared widths, coefficient table and FSM states for the forward DCT8
// Purpose: common definitions for dct8_fwd_serial and dct8_row_mac.
//   DW      sample / coefficient width (signed)
//   AW      accumulator width: DW + 7 coefficient bits + 3 bits of 8-term growth
//   state_t LOAD (collect 8 samples) / EMIT (produce 8 coefficients)
//   coef()  C[k][n] of the HEVC 8-point forward transform matrix
package dct8_pkg;

  localparam int DW = 25;
  localparam int AW = 35;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  typedef logic signed [7:0] coef_t;

  localparam coef_t C [8][8] = '{
    '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64,  8'sd64},
    '{ 8'sd89,  8'sd75,  8'sd50,  8'sd18, -8'sd18, -8'sd50, -8'sd75, -8'sd89},
    '{ 8'sd83,  8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36,  8'sd36,  8'sd83},
    '{ 8'sd75, -8'sd18, -8'sd89, -8'sd50,  8'sd50,  8'sd89,  8'sd18, -8'sd75},
    '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64,  8'sd64, -8'sd64, -8'sd64,  8'sd64},
    '{ 8'sd50, -8'sd89,  8'sd18,  8'sd75, -8'sd75, -8'sd18,  8'sd89, -8'sd50},
    '{ 8'sd36, -8'sd83,  8'sd83, -8'sd36, -8'sd36,  8'sd83, -8'sd83,  8'sd36},
    '{ 8'sd18, -8'sd50,  8'sd75, -8'sd89,  8'sd89, -8'sd75,  8'sd50, -8'sd18}
  };

  function automatic coef_t coef(input logic [2:0] k, input logic [2:0] n);
    return C[k][n];
  endfunction

endpackage

// File: rtl/dct8_row_mac.sv
// rtl/dct8_row_mac.sv - combinational dot product of one DCT8 row with the sample buffer
// Purpose: y = (sum_n C[k][n]*samples[n] + add) >>> shift, truncated to DW bits.
// Ports:
//   samples  in   8 x DW  buffered signed samples x[0..7]
//   k        in   3       coefficient row to evaluate
//   shift    in   6       arithmetic right-shift amount (>= AW gives all sign bits)
//   add      in   6       unsigned rounding offset
//   y        out  DW      signed coefficient, two's-complement wrap
module dct8_row_mac
  import dct8_pkg::*;
(
  input  logic [7:0][DW-1:0] samples,
  input  logic [2:0]         k,
  input  logic [5:0]         shift,
  input  logic [5:0]         add,
  output logic [DW-1:0]      y
);

  logic signed [AW-1:0] acc;
  logic [AW-1:0]        cx;
  logic [AW-1:0]        xx;
  coef_t                c;
  logic [5:0]           shamt;

  // Both operands are sign-extended to AW bits, so the modulo-2^AW product
  // equals the signed product; the sum never exceeds AW bits.
  always_comb begin
    acc = {{(AW-6){1'b0}}, add};
    cx  = '0;
    xx  = '0;
    c   = '0;
    for (int n = 0; n < 8; n++) begin
      c   = coef(k, 3'(n));
      cx  = {{(AW-8){c[7]}}, c};
      xx  = {{(AW-DW){samples[3'(n)][DW-1]}}, samples[3'(n)]};
      acc = acc + cx * xx;
    end
  end

  // Shifting by AW-1 already leaves only sign bits, so larger amounts clamp there.
  always_comb begin
    shamt = (shift >= 6'(AW)) ? 6'(AW - 1) : shift;
    y     = DW'(acc >>> shamt);
  end

endmodule

// File: rtl/dct8_fwd_serial.sv
// rtl/dct8_fwd_serial.sv - serial-in / serial-out forward 8-point integer DCT
// Purpose: collects 8 signed samples over a valid/ready stream, then emits the
// 8 transform coefficients one per accepted output beat with their index.
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   in_valid   in   1   sample valid
//   in_ready   out  1   high only while collecting samples
//   in_data    in   DW  signed sample x[n], arrival order n = 0..7
//   shift      in   6   right-shift amount, captured with x[0]
//   add        in   6   rounding offset, captured with x[0]
//   out_valid  out  1   coefficient valid
//   out_ready  in   1   downstream accepts coefficient
//   out_data   out  DW  signed coefficient y[k]
//   out_index  out  3   k of out_data
//   out_last   out  1   high with k = 7
module dct8_fwd_serial
  import dct8_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [5:0]    shift,
  input  logic [5:0]    add,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_index,
  output logic          out_last
);

  state_t             state;
  state_t             state_n;
  logic [2:0]         n_cnt;
  logic [2:0]         k_cnt;
  logic [7:0][DW-1:0] samples;
  logic [5:0]         shift_q;
  logic [5:0]         add_q;
  logic [DW-1:0]      y;
  logic               in_fire;
  logic               load_out;

  assign in_ready = (state == LOAD);
  assign in_fire  = in_valid && in_ready;
  // The output register takes a new coefficient whenever it is empty or being drained.
  assign load_out = (state == EMIT) && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD: if (in_fire && (n_cnt == 3'd7)) state_n = EMIT;
      EMIT: if (load_out && (k_cnt == 3'd7)) state_n = LOAD;
    endcase
  end

  // Sample buffer; shift/add belong to the block and are captured only with x[0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_cnt   <= '0;
      samples <= '0;
      shift_q <= '0;
      add_q   <= '0;
    end else if (in_fire) begin
      samples[n_cnt] <= in_data;
      n_cnt          <= n_cnt + 3'd1;
      if (n_cnt == 3'd0) begin
        shift_q <= shift;
        add_q   <= add;
      end
    end
  end

  dct8_row_mac u_row_mac (
    .samples (samples),
    .k       (k_cnt),
    .shift   (shift_q),
    .add     (add_q),
    .y       (y)
  );

  // Output register; k_cnt wraps 7 -> 0 on the last load, ready for the next block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (load_out) begin
      out_data  <= y;
      out_index <= k_cnt;
      out_last  <= (k_cnt == 3'd7);
      out_valid <= 1'b1;
      k_cnt     <= k_cnt + 3'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct8_fwd_serial.sv
// tb/tb_dct8_fwd_serial.sv - scoreboard bench for the serial forward DCT8
`timescale 1ns/1ps
module tb_dct8_fwd_serial;

  localparam int DW = 25;

  typedef logic signed [DW-1:0] samp_t;
  typedef samp_t blk_t [8];
  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    idx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [5:0]    shift = '0;
  logic [5:0]    add = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [2:0]    out_index;
  logic          out_last;

  int checks = 0;
  int failures = 0;

  int c_tab [8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}
  };

  exp_t q[$];
  int   n_out = 0;
  bit   emit_busy = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   prev_valid = 1'b0;
  bit   prev_fire = 1'b0;
  bit   hold = 1'b0;
  logic [DW-1:0] hold_data;
  logic [2:0]    hold_idx;
  logic          hold_last;

  dct8_fwd_serial dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shift     (shift),
    .add       (add),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_y(input blk_t x, input int k, input int sh, input int ad);
    longint acc = longint'(ad);
    for (int n = 0; n < 8; n++) acc += longint'(c_tab[k][n]) * longint'(x[n]);
    if (sh >= 35) acc = (acc < 0) ? -64'sd1 : 64'sd0;
    else          acc = acc >>> sh;
    return acc[DW-1:0];
  endfunction

  function automatic blk_t fill(input int v0, input int vr);
    blk_t x;
    x[0] = DW'(v0);
    for (int n = 1; n < 8; n++) x[n] = DW'(vr);
    return x;
  endfunction

  task automatic push_exp(input int e[8]);
    exp_t t;
    for (int i = 0; i < 8; i++) begin
      t.data = DW'(e[i]);
      t.idx  = 3'(i);
      t.last = (i == 7);
      q.push_back(t);
    end
  endtask

  task automatic push_model(input blk_t x, input int sh, input int ad);
    exp_t t;
    for (int i = 0; i < 8; i++) begin
      t.data = model_y(x, i, sh, ad);
      t.idx  = 3'(i);
      t.last = (i == 7);
      q.push_back(t);
    end
  endtask

  // Drives nsamp samples; shift/add carry the block value only while x[0] is
  // pending and random junk afterwards.
  task automatic drive_block(input blk_t x, input logic [5:0] sh, input logic [5:0] ad,
                             input int nsamp, input bit gaps);
    int i = 0;
    int g = 0;
    while (i < nsamp && g < 2000) begin
      @(negedge clk);
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = in_valid ? x[i] : DW'($urandom);
      shift    = (i == 0) ? sh : 6'($urandom);
      add      = (i == 0) ? ad : 6'($urandom);
      if (in_valid && in_ready) i++;
      g++;
    end
    check_eq("drive_timeout", 64'(g < 2000), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (i == 8) emit_busy = 1'b1;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((q.size() != 0 || emit_busy) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain_timeout", 64'(g < 3000), 64'd1);
  endtask

  task automatic run_block(input blk_t x, input logic [5:0] sh, input logic [5:0] ad, input int e[8]);
    push_exp(e);
    drive_block(x, sh, ad, 8, 1'b0);
    wait_drain();
  endtask

  // Output monitor: compares each accepted coefficient against the queue head,
  // checks stability under stall and in_ready against the expected phase.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
      hold       = 1'b0;
      emit_busy  = 1'b0;
      check_eq("out_valid_in_reset", 64'(out_valid), 64'd0);
    end else begin
      if (hold) begin
        check_eq("stall_valid", 64'(out_valid), 64'd1);
        check_eq("stall_data", 64'(out_data), 64'(hold_data));
        check_eq("stall_index", 64'(out_index), 64'(hold_idx));
        check_eq("stall_last", 64'(out_last), 64'(hold_last));
      end
      if (out_valid && (!prev_valid || prev_fire) && out_index == 3'd7) emit_busy = 1'b0;
      check_eq("in_ready", 64'(in_ready), 64'(!emit_busy));
      out_ready = rdy_rand ? ($urandom_range(0, 9) < 6) : 1'b1;
      if (out_valid && out_ready) begin
        check_eq("queue_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_t t;
          t = q.pop_front();
          check_eq("out_data", 64'(out_data), 64'(t.data));
          check_eq("out_index", 64'(out_index), 64'(t.idx));
          check_eq("out_last", 64'(out_last), 64'(t.last));
        end
        n_out++;
      end
      prev_fire  = out_valid && out_ready;
      hold       = out_valid && !out_ready;
      hold_data  = out_data;
      hold_idx   = out_index;
      hold_last  = out_last;
      prev_valid = out_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   e[8];
    blk_t x;
    int   base;
    int   g;
    int   sh;
    int   ad;

    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_index", 64'(out_index), 64'd0);
    check_eq("rst_out_last", 64'(out_last), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    e = '{512, 0, 0, 0, 0, 0, 0, 0};
    run_block(fill(1, 1), 6'd0, 6'd0, e);
    e = '{64, 89, 83, 75, 64, 50, 36, 18};
    run_block(fill(1, 0), 6'd0, 6'd0, e);
    e = '{8, 0, 0, 0, 0, 0, 0, 0};
    run_block(fill(1, 1), 6'd6, 6'd32, e);
    e = '{-16, -23, -21, -19, -16, -13, -9, -5};
    run_block(fill(-1, 0), 6'd2, 6'd0, e);
    e = '{-1, -1, -1, -1, -1, -1, -1, -1};
    run_block(fill(-1, 0), 6'd40, 6'd0, e);
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_block(fill(1, 1), 6'd63, 6'd5, e);
    e = '{-512, 0, 0, 0, 0, 0, 0, 0};
    run_block(fill(16777215, 16777215), 6'd0, 6'd0, e);

    // Reset after 5 samples of a block.
    drive_block(fill(7, 7), 6'd0, 6'd0, 5, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midload_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midload_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("midload_post_in_ready", 64'(in_ready), 64'd1);
    e = '{64, 89, 83, 75, 64, 50, 36, 18};
    run_block(fill(1, 0), 6'd0, 6'd0, e);

    // Reset once y[3] of a block has been accepted.
    base = n_out;
    e = '{128, 178, 166, 150, 128, 100, 72, 36};
    push_exp(e);
    drive_block(fill(2, 0), 6'd0, 6'd0, 8, 1'b0);
    g = 0;
    while (n_out < base + 4 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("emit_wait_timeout", 64'(g < 100), 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midemit_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midemit_rst_out_data", 64'(out_data), 64'd0);
    check_eq("midemit_rst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    emit_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("midemit_post_in_ready", 64'(in_ready), 64'd1);
    e = '{512, 0, 0, 0, 0, 0, 0, 0};
    run_block(fill(1, 1), 6'd0, 6'd0, e);

    // Random blocks with input gaps and output backpressure.
    rdy_rand = 1'b1;
    for (int b = 0; b < 100; b++) begin
      for (int n = 0; n < 8; n++) begin
        if (b % 3 == 0) x[n] = DW'($urandom);
        else            x[n] = DW'(int'($urandom_range(0, 511)) - 256);
      end
      sh = (b % 5 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 12));
      ad = int'($urandom_range(0, 63));
      push_model(x, sh, ad);
      drive_block(x, 6'(sh), 6'(ad), 8, 1'b1);
    end
    wait_drain();
    rdy_rand = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("final_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
